// File: rtl/plot_sequencer.sv
// Per-frame render controller: clears the back buffer, draws the polyline segment by segment,
// then swaps buffers on vsync. Also muxes the single frame_buffer write port to the active drawer.
module plot_sequencer #(
  parameter int POINT_COUNT = 640,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             vsync,
  output logic             point_req,
  output logic [IDX_W-1:0] point_idx,
  input  logic             point_ack,
  input  logic [9:0]       point_x,
  input  logic [8:0]       point_y,
  output logic             fill_start,
  input  logic             fill_ready,
  output logic             line_start,
  input  logic             line_ready,
  output logic [9:0]       x1,
  output logic [8:0]       y1,
  output logic [9:0]       x2,
  output logic [8:0]       y2,
  input  logic             fill_we,
  input  logic [18:0]      fill_addr,
  input  logic             fill_data,
  input  logic             line_we,
  input  logic [18:0]      line_addr,
  input  logic             line_data,
  output logic             fb_we,
  output logic [18:0]      fb_addr,
  output logic             fb_data,
  output logic             swap,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FILL_GO   = 4'd1,
    FILL_WAIT = 4'd2,
    FETCH0    = 4'd3,
    FETCH     = 4'd4,
    LINE_GO   = 4'd5,
    LINE_WAIT = 4'd6,
    WAIT_VS   = 4'd7,
    SWAP      = 4'd8
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(POINT_COUNT - 1);
  localparam logic             SKIP_LINES = (POINT_COUNT < 32'sd2);

  state_t           state_r, next_state_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [9:0]       prev_x_r, prev_x_nxt_s, x1_r, x1_nxt_s, x2_r, x2_nxt_s;
  logic [8:0]       prev_y_r, prev_y_nxt_s, y1_r, y1_nxt_s, y2_r, y2_nxt_s;
  logic             req_r, guard_r, fill_start_r, line_start_r, swap_r, busy_r, overrun_r;
  logic             ack_take_s;

  // An ack only counts while a request is actually outstanding.
  assign ack_take_s = req_r & point_ack;

  // Next-state and datapath update; guard_r masks ready in the cycle right after a start pulse.
  always_comb begin
    next_state_s = state_r;
    idx_nxt_s    = idx_r;
    prev_x_nxt_s = prev_x_r;
    prev_y_nxt_s = prev_y_r;
    x1_nxt_s     = x1_r;
    y1_nxt_s     = y1_r;
    x2_nxt_s     = x2_r;
    y2_nxt_s     = y2_r;
    case (state_r)
      IDLE: begin
        if (enable && fill_ready && line_ready) begin
          next_state_s = FILL_GO;
          idx_nxt_s    = {IDX_W{1'b0}};
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL_GO: next_state_s = FILL_WAIT;
      FILL_WAIT: begin
        if (!guard_r && fill_ready) begin
          next_state_s = SKIP_LINES ? WAIT_VS : FETCH0;
        end else begin
          next_state_s = FILL_WAIT;
        end
      end
      FETCH0: begin
        if (ack_take_s) begin
          prev_x_nxt_s = point_x;
          prev_y_nxt_s = point_y;
          idx_nxt_s    = IDX_W'(1);
          next_state_s = FETCH;
        end else begin
          next_state_s = FETCH0;
        end
      end
      FETCH: begin
        if (ack_take_s) begin
          x1_nxt_s     = prev_x_r;
          y1_nxt_s     = prev_y_r;
          x2_nxt_s     = point_x;
          y2_nxt_s     = point_y;
          next_state_s = LINE_GO;
        end else begin
          next_state_s = FETCH;
        end
      end
      LINE_GO: next_state_s = LINE_WAIT;
      LINE_WAIT: begin
        if (!guard_r && line_ready) begin
          prev_x_nxt_s = x2_r;
          prev_y_nxt_s = y2_r;
          if (idx_r == LAST_IDX) begin
            next_state_s = WAIT_VS;
          end else begin
            idx_nxt_s    = idx_r + IDX_W'(1);
            next_state_s = FETCH;
          end
        end else begin
          next_state_s = LINE_WAIT;
        end
      end
      WAIT_VS: begin
        if (vsync) begin
          next_state_s = SWAP;
        end else begin
          next_state_s = WAIT_VS;
        end
      end
      SWAP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      prev_x_r     <= 10'd0;
      prev_y_r     <= 9'd0;
      x1_r         <= 10'd0;
      y1_r         <= 9'd0;
      x2_r         <= 10'd0;
      y2_r         <= 9'd0;
      req_r        <= 1'b0;
      guard_r      <= 1'b0;
      fill_start_r <= 1'b0;
      line_start_r <= 1'b0;
      swap_r       <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      idx_r        <= idx_nxt_s;
      prev_x_r     <= prev_x_nxt_s;
      prev_y_r     <= prev_y_nxt_s;
      x1_r         <= x1_nxt_s;
      y1_r         <= y1_nxt_s;
      x2_r         <= x2_nxt_s;
      y2_r         <= y2_nxt_s;
      req_r        <= ((next_state_s == FETCH0) || (next_state_s == FETCH)) && !ack_take_s;
      guard_r      <= (state_r == FILL_GO) || (state_r == LINE_GO);
      fill_start_r <= (next_state_s == FILL_GO);
      line_start_r <= (next_state_s == LINE_GO);
      swap_r       <= (next_state_s == SWAP);
      busy_r       <= (next_state_s != IDLE);
      overrun_r    <= overrun_r | (vsync && (state_r != IDLE) && (state_r != WAIT_VS));
    end
  end

  // Write-port grant follows the registered state, so it includes the ready-sampling cycle.
  always_comb begin
    fb_we   = 1'b0;
    fb_addr = 19'd0;
    fb_data = 1'b0;
    case (state_r)
      FILL_GO, FILL_WAIT: begin
        fb_we   = fill_we;
        fb_addr = fill_addr;
        fb_data = fill_data;
      end
      LINE_GO, LINE_WAIT: begin
        fb_we   = line_we;
        fb_addr = line_addr;
        fb_data = line_data;
      end
      default: begin
        fb_we   = 1'b0;
        fb_addr = 19'd0;
        fb_data = 1'b0;
      end
    endcase
  end

  assign point_req  = req_r;
  assign point_idx  = idx_r;
  assign fill_start = fill_start_r;
  assign line_start = line_start_r;
  assign x1         = x1_r;
  assign y1         = y1_r;
  assign x2         = x2_r;
  assign y2         = y2_r;
  assign swap       = swap_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_plot_sequencer.sv
// Directed bench for plot_sequencer: a 3-point instance for the main flow and a
// 1-point instance for the degenerate no-segment frame.
module tb_plot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, enable1, vsync, point_ack, fill_ready, line_ready;
  logic [9:0]  point_x;
  logic [8:0]  point_y;
  logic        fill_we, fill_data, line_we, line_data;
  logic [18:0] fill_addr, line_addr;

  logic        point_req, fill_start, line_start, fb_we, fb_data, swap, busy, overrun;
  logic [9:0]  point_idx, x1, x2;
  logic [8:0]  y1, y2;
  logic [18:0] fb_addr;

  logic        point_req1, fill_start1, line_start1, fb_we1, fb_data1, swap1, busy1, overrun1;
  logic [9:0]  point_idx1, x1_1, x2_1;
  logic [8:0]  y1_1, y2_1;
  logic [18:0] fb_addr1;

  int checks = 0;
  int errors = 0;

  logic [9:0] ex1 [2] = '{10'd100, 10'd600};
  logic [8:0] ey1 [2] = '{9'd200,  9'd400};
  logic [9:0] ex2 [2] = '{10'd600, 10'd0};
  logic [8:0] ey2 [2] = '{9'd400,  9'd0};
  logic [9:0] px  [3] = '{10'd100, 10'd600, 10'd0};
  logic [8:0] py  [3] = '{9'd200,  9'd400,  9'd0};
  int         dly [3] = '{0, 3, 0};

  plot_sequencer #(.POINT_COUNT(3), .IDX_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
    .point_req(point_req), .point_idx(point_idx), .point_ack(point_ack),
    .point_x(point_x), .point_y(point_y),
    .fill_start(fill_start), .fill_ready(fill_ready),
    .line_start(line_start), .line_ready(line_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .line_we(line_we), .line_addr(line_addr), .line_data(line_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .swap(swap), .busy(busy), .overrun(overrun)
  );

  plot_sequencer #(.POINT_COUNT(1), .IDX_W(10)) u_one (
    .clk(clk), .rst_n(rst_n), .enable(enable1), .vsync(vsync),
    .point_req(point_req1), .point_idx(point_idx1), .point_ack(point_ack),
    .point_x(point_x), .point_y(point_y),
    .fill_start(fill_start1), .fill_ready(fill_ready),
    .line_start(line_start1), .line_ready(line_ready),
    .x1(x1_1), .y1(y1_1), .x2(x2_1), .y2(y2_1),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .line_we(line_we), .line_addr(line_addr), .line_data(line_data),
    .fb_we(fb_we1), .fb_addr(fb_addr1), .fb_data(fb_data1),
    .swap(swap1), .busy(busy1), .overrun(overrun1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; enable1 = 1'b0; vsync = 1'b0; point_ack = 1'b0;
    point_x = 10'd0; point_y = 9'd0; fill_ready = 1'b1; line_ready = 1'b1;
    fill_we = 1'b1; fill_addr = 19'h12345; fill_data = 1'b1;
    line_we = 1'b1; line_addr = 19'h54321; line_data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({point_req, fill_start, line_start, swap, busy, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {point_req, fill_start, line_start, swap, busy, overrun});
    end
    checks++;
    if (point_idx !== 10'd0) begin
      errors++; $display("FAIL reset_idx got %0d want 0", point_idx);
    end
    checks++;
    if ({x1, y1, x2, y2} !== 38'd0) begin
      errors++; $display("FAIL reset_coords got %h want 0", {x1, y1, x2, y2});
    end
    checks++;
    if ({fb_we, fb_addr, fb_data} !== 21'd0) begin
      errors++; $display("FAIL reset_fb got %h want 0", {fb_we, fb_addr, fb_data});
    end
    checks++;
    if ({point_req1, busy1, swap1, overrun1, fb_we1} !== 5'b0) begin
      errors++; $display("FAIL reset_one got %b want 00000", {point_req1, busy1, swap1, overrun1, fb_we1});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    int fs_cnt;
    fs_cnt = 0;
    enable = 1'b1;
    step();
    checks++;
    if (fill_start !== 1'b1) begin
      errors++; $display("FAIL fill_start_first got %b want 1", fill_start);
    end
    for (int k = 0; k < 30; k++) begin
      if (fill_start === 1'b1) fs_cnt++;
      enable     = 1'b0;
      fill_ready = (k >= 1 && k <= 20) ? 1'b0 : 1'b1;
      fill_we    = (k % 3 != 2);
      fill_addr  = 19'(k * 7 + 3);
      fill_data  = k[0];
      @(negedge clk);
      checks++;
      if (k <= 21) begin
        if ({fb_we, fb_addr, fb_data} !== {fill_we, fill_addr, fill_data}) begin
          errors++;
          $display("FAIL fill_grant k=%0d got %h want %h", k, {fb_we, fb_addr, fb_data}, {fill_we, fill_addr, fill_data});
        end
      end else begin
        if ({fb_we, fb_addr, fb_data} !== 21'd0) begin
          errors++; $display("FAIL fill_nogrant k=%0d got %h want 0", k, {fb_we, fb_addr, fb_data});
        end
      end
      step();
    end
    fill_ready = 1'b1;
    checks++;
    if (fs_cnt != 1) begin
      errors++; $display("FAIL fill_start_count got %0d want 1", fs_cnt);
    end
    checks++;
    if ({point_req, point_idx} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL fetch0_req got req=%b idx=%0d want req=1 idx=0", point_req, point_idx);
    end
  endtask

  task automatic test_points();
    int wait_cnt, nacc, nls, lr_busy, swaps;
    bit vs_sent, done;
    logic [9:0] idx_seen [3];
    wait_cnt = 0; nacc = 0; nls = 0; lr_busy = 0; swaps = 0; vs_sent = 1'b0; done = 1'b0;
    for (int i = 0; i < 3; i++) idx_seen[i] = 10'h3FF;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (swap === 1'b1) swaps++;
      if (line_start === 1'b1) begin
        if (nls < 2) begin
          checks++;
          if ({x1, y1, x2, y2} !== {ex1[nls], ey1[nls], ex2[nls], ey2[nls]}) begin
            errors++;
            $display("FAIL line%0d_coords got (%0d,%0d)-(%0d,%0d) want (%0d,%0d)-(%0d,%0d)", nls,
                     x1, y1, x2, y2, ex1[nls], ey1[nls], ex2[nls], ey2[nls]);
          end
        end
        nls++;
        lr_busy = 5;
      end else if (lr_busy > 0) begin
        line_ready = 1'b0;
        lr_busy--;
      end else begin
        line_ready = 1'b1;
      end
      if (nls == 1 && lr_busy == 1 && line_ready == 1'b0 && !vs_sent) begin
        vsync = 1'b1; vs_sent = 1'b1;
      end else begin
        vsync = 1'b0;
      end
      if (point_req === 1'b1 && nacc < 3) begin
        if (wait_cnt == dly[nacc]) begin
          point_ack = 1'b1; point_x = px[nacc]; point_y = py[nacc];
          idx_seen[nacc] = point_idx;
          nacc++; wait_cnt = 0;
        end else begin
          point_ack = 1'b0; wait_cnt++;
        end
      end else begin
        point_ack = 1'b1; point_x = 10'h3FF; point_y = 9'h1FF;
      end
      if (nls == 2 && lr_busy == 0 && line_ready == 1'b1) done = 1'b1;
      else step();
    end
    point_ack = 1'b0;
    vsync = 1'b0;
    checks++;
    if (nls != 2) begin
      errors++; $display("FAIL line_start_count got %0d want 2 (timeout or extra)", nls);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (idx_seen[i] !== 10'(i)) begin
        errors++; $display("FAIL point_idx_seq[%0d] got %0d want %0d", i, idx_seen[i], i);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set got %b want 1", overrun);
    end
    checks++;
    if (swaps != 0) begin
      errors++; $display("FAIL early_swap got %0d want 0", swaps);
    end
  endtask

  task automatic test_swap();
    int bad;
    bad = 0;
    line_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (swap !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wait_vs_hold got %0d bad cycles want 0", bad);
    end
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    checks++;
    if (swap !== 1'b1) begin
      errors++; $display("FAIL swap_pulse got %b want 1", swap);
    end
    step();
    checks++;
    if ({swap, busy} !== 2'b00) begin
      errors++; $display("FAIL swap_end got swap=%b busy=%b want 0 0", swap, busy);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_sticky got %b want 1", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    point_ack = 1'b1; point_x = 10'd5; point_y = 9'd7;
    fill_ready = 1'b1; line_ready = 1'b1;
    enable = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      enable = 1'b0;
      vsync  = (c == 14);
      want = {(c == 1), (c == 7 || c == 11), (c == 15)};
      checks++;
      if ({fill_start, line_start, swap} !== want) begin
        errors++;
        $display("FAIL b2b_timing c=%0d got %b want %b", c, {fill_start, line_start, swap}, want);
      end
    end
    vsync = 1'b0; point_ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    point_ack = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (5) step();
    checks++;
    if (point_req !== 1'b1) begin
      errors++; $display("FAIL mid_pre_req got %b want 1", point_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({point_req, busy, swap, overrun} !== 4'b0) begin
      errors++; $display("FAIL mid_async_reset got %b want 0000", {point_req, busy, swap, overrun});
    end
    line_ready = 1'b0;
    enable = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy !== 1'b0 || fill_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_hold_idle got %0d bad cycles want 0", bad);
    end
    line_ready = 1'b1;
    step();
    enable = 1'b0;
    checks++;
    if ({fill_start, busy} !== 2'b11) begin
      errors++; $display("FAIL mid_restart got %b want 11", {fill_start, busy});
    end
  endtask

  task automatic test_single();
    logic [3:0] want;
    fill_ready = 1'b1; line_ready = 1'b1; point_ack = 1'b0;
    enable1 = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      enable1 = 1'b0;
      vsync   = (c == 9);
      want = {1'b0, 1'b0, (c == 1), (c == 10)};
      checks++;
      if ({point_req1, line_start1, fill_start1, swap1} !== want) begin
        errors++;
        $display("FAIL single_timing c=%0d got %b want %b", c, {point_req1, line_start1, fill_start1, swap1}, want);
      end
    end
    vsync = 1'b0;
    checks++;
    if ({busy1, overrun1} !== 2'b00) begin
      errors++; $display("FAIL single_end got busy=%b overrun=%b want 0 0", busy1, overrun1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_points();
    test_swap();
    test_back_to_back();
    test_reset_mid();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plot_sequencer.md
Name: plot_sequencer

Overview:
Per-frame controller for the plot renderer. It clears the back buffer with fill_drawer, then walks a point list and draws one line_drawer segment between each pair of consecutive points. It waits for vertical sync and pulses the frame_buffer swap. It also owns the single frame_buffer write port and grants it to whichever drawer is active.

Parameters:
POINT_COUNT, 640, number of polyline points per frame (segments = POINT_COUNT-1)
IDX_W, 10, width of point_idx; must satisfy 2^IDX_W >= POINT_COUNT

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; when 1, a new frame render starts from IDLE
vsync  in  1  one-cycle pulse at start of vertical blank
point_req  out  1  point fetch request, held until point_ack
point_idx  out  IDX_W  index of requested point, stable while point_req=1
point_ack  in  1  point_x/point_y valid this cycle
point_x  in  10  point x coordinate
point_y  in  9  point y coordinate
fill_start  out  1  one-cycle start pulse to fill_drawer
fill_ready  in  1  fill_drawer idle
line_start  out  1  one-cycle start pulse to line_drawer
line_ready  in  1  line_drawer idle
x1  out  10  segment start x, registered
y1  out  9  segment start y, registered
x2  out  10  segment end x, registered
y2  out  9  segment end y, registered
fill_we / fill_addr / fill_data  in  1/19/1  fill_drawer write port
line_we / line_addr / line_data  in  1/19/1  line_drawer write port
fb_we / fb_addr / fb_data  out  1/19/1  frame_buffer write port
swap  out  1  one-cycle buffer swap pulse
busy  out  1  1 in any state other than IDLE
overrun  out  1  sticky: vsync seen while rendering

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: point_req, point_idx, fill_start, line_start, x1..y2, swap, busy, overrun. fb_* are 0 because no grant is active. Drawers are not reset by this block.
- States: IDLE, FILL_GO, FILL_WAIT, FETCH0, FETCH, LINE_GO, LINE_WAIT, WAIT_VS, SWAP.
- IDLE -> FILL_GO when enable & fill_ready & line_ready.
- FILL_GO: fill_start=1 for exactly one cycle. The next cycle is a guard cycle in which ready is ignored, then FILL_WAIT.
- FILL_WAIT: stay until fill_ready=1. Then go to FETCH0, or to WAIT_VS if POINT_COUNT<2.
- FETCH0 / FETCH: point_req=1 with point_idx = current index. On point_ack, capture point_x/point_y in that same cycle and drop point_req in the next cycle.
  - FETCH0 fetches index 0 into prev, then enters FETCH with index 1.
  - FETCH loads x1/y1 = prev and x2/y2 = fetched point, then goes to LINE_GO.
- LINE_GO: line_start=1 for one cycle, followed by one guard cycle, then LINE_WAIT.
- LINE_WAIT: when line_ready=1, copy prev <= (x2, y2).
  - If index = POINT_COUNT-1, go to WAIT_VS.
  - Otherwise increment the index and return to FETCH.
- x1..y2 stay stable from FETCH exit until the next FETCH exit.
- WAIT_VS: wait for vsync=1, then SWAP. SWAP holds swap=1 for one cycle, then IDLE.
- A vsync in any busy state other than WAIT_VS sets overrun (sticky until reset). That vsync is otherwise ignored; the swap waits for the next vsync.
- Write arbitration is combinational from the registered state:
  - FILL_GO through FILL_WAIT: fb_* = fill_*.
  - LINE_GO through LINE_WAIT: fb_* = line_*.
  - All other states: fb_we=0, fb_addr=0, fb_data=0.
  - The grant covers the cycle in which ready is sampled high.
- enable dropping mid-frame does not abort; the current frame completes, including its swap.
- point_ack while point_req=0 is ignored.
- Latency, POINT_COUNT=2, zero-wait ack and drawers: IDLE -> swap is bounded by fill time + line time + the wait for vsync + fixed overhead. Overhead is at most 12 cycles and is checked exactly in the test plan.
- Reset asserted mid-operation: immediate return to IDLE with outputs 0. On release, rendering restarts only once both drawers report ready.

Test Plan:
- Reset then enable=1, fill_ready models a 20-cycle drawer -> fill_start pulses exactly once and fb_* mirrors fill_* only during the fill phase; fb_we=0 elsewhere.
- POINT_COUNT=3, points (100,200),(600,400),(0,0) with ack delays 0 and 3 cycles -> two line_start pulses. First pulse has x1=100,y1=200,x2=600,y2=400; second has x1=600,y1=400,x2=0,y2=0. point_idx sequence is 0,1,2.
- Drawing completes, vsync asserted 50 cycles later -> swap=1 for one cycle on the cycle after vsync, then busy=0.
- vsync pulsed during LINE_WAIT -> overrun=1 and stays 1; no swap until the next vsync after WAIT_VS is reached.
- rst_n pulled low during FETCH with point_req=1 -> point_req, busy and swap go to 0 asynchronously. With line_ready held 0 after release, the block stays in IDLE until line_ready=1.
- POINT_COUNT=1 -> no point_req and no line_start; after the fill, swap follows the next vsync.
